// File: rtl/qbert_only_loader_pkg.sv
// Shared types and constants for the Qbert memory loader.
package qbert_only_loader_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int LANE_W         = 2;

endpackage

// File: rtl/qbert_only_byte_packer.sv
// Little-endian byte-to-word packer: lane counter, assembly word and lane mask.
module qbert_only_byte_packer
  import qbert_only_loader_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear_i,
  input  logic                             load_i,
  input  logic [BYTE_W-1:0]                data_i,
  output logic [BYTES_PER_WORD*BYTE_W-1:0] word_o,
  output logic [BYTES_PER_WORD-1:0]        mask_o,
  output logic                             full_o
);

  logic [LANE_W-1:0]                lane_q;
  logic [BYTES_PER_WORD*BYTE_W-1:0] word_q;
  logic [BYTES_PER_WORD-1:0]        mask_q;

  // Clearing zeroes the word so unfilled lanes go out as 0 on a partial write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      word_q <= '0;
      mask_q <= '0;
    end else if (clear_i) begin
      lane_q <= '0;
      word_q <= '0;
      mask_q <= '0;
    end else if (load_i) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (lane_q == LANE_W'(i)) begin
          word_q[i*BYTE_W +: BYTE_W] <= data_i;
          mask_q[i]                  <= 1'b1;
        end
      end
      lane_q <= lane_q + 1'b1;
    end
  end

  assign word_o = word_q;
  assign mask_o = mask_q;
  assign full_o = (lane_q == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/qbert_only_mem_loader.sv
// Byte-stream to 32-bit memory write master for the Qbert on-chip RAM.
// Optional QBERT_LOADER_CHECKSUM_EN adds a running sum of written words.
module qbert_only_mem_loader
  import qbert_only_loader_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 5000,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count,
`ifdef QBERT_LOADER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic              overflow
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wcnt_q;
  logic              last_q;
  logic              ovf_q;

  logic        accept;
  logic        in_range;
  logic        wr_en;
  logic [31:0] pk_word;
  logic [3:0]  pk_mask;
  logic        pk_full;

  assign accept   = (state_q == FILL) && s_valid;
  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign wr_en    = (state_q == WRITE) && in_range;

  qbert_only_byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q != FILL),
    .load_i  (accept),
    .data_i  (s_data),
    .word_o  (pk_word),
    .mask_o  (pk_mask),
    .full_o  (pk_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= BASE_L;
      wcnt_q  <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= FILL;
          addr_q  <= BASE_L;
          wcnt_q  <= '0;
          last_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end
        FILL: if (accept) begin
          last_q <= s_last;
          if (s_last || pk_full) state_q <= WRITE;
        end
        // Out-of-range word is dropped and the load ends; the stream is left stalled.
        WRITE: if (!in_range) begin
          ovf_q   <= 1'b1;
          state_q <= DONE;
        end else begin
          addr_q  <= addr_q + 1'b1;
          wcnt_q  <= wcnt_q + 1'b1;
          state_q <= last_q ? DONE : FILL;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef QBERT_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           csum_q <= '0;
    else if (state_q == IDLE && start)   csum_q <= '0;
    else if (wr_en)                      csum_q <= csum_q + pk_word;
  end

  assign checksum = csum_q;
`endif

  assign s_ready      = (state_q == FILL);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign m_address    = addr_q;
  assign m_chipselect = wr_en;
  assign m_write      = wr_en;
  assign m_byteenable = wr_en ? pk_mask : 4'b0000;
  assign m_writedata  = wr_en ? pk_word : 32'h0;
  assign word_count   = wcnt_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_qbert_only_mem_loader.sv
// Scoreboard bench: instance 0 at BASE_ADDR=0, instance 1 at BASE_ADDR=4998.
module tb_qbert_only_mem_loader;

  typedef struct packed {
    logic [12:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  logic        clk, reset;
  logic        start   [2];
  logic [7:0]  s_data  [2];
  logic        s_valid [2];
  logic        s_last  [2];
  logic        s_ready [2];
  logic [12:0] m_address [2];
  logic [3:0]  m_byteenable [2];
  logic        m_chipselect [2];
  logic        m_write [2];
  logic [31:0] m_writedata [2];
  logic        busy [2];
  logic        done [2];
  logic [12:0] word_count [2];
  logic        overflow [2];
  logic [31:0] checksum [2];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  done_cnt [2];
  int  wcyc [$];
  wr_t expq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qbert_only_mem_loader #(.ADDR_W(13), .DEPTH(5000), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .s_data(s_data[0]),
    .s_valid(s_valid[0]), .s_last(s_last[0]), .s_ready(s_ready[0]),
    .m_address(m_address[0]), .m_byteenable(m_byteenable[0]),
    .m_chipselect(m_chipselect[0]), .m_write(m_write[0]),
    .m_writedata(m_writedata[0]), .busy(busy[0]), .done(done[0]),
    .word_count(word_count[0]),
`ifdef QBERT_LOADER_CHECKSUM_EN
    .checksum(checksum[0]),
`endif
    .overflow(overflow[0])
  );

  qbert_only_mem_loader #(.ADDR_W(13), .DEPTH(5000), .BASE_ADDR(4998)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .s_data(s_data[1]),
    .s_valid(s_valid[1]), .s_last(s_last[1]), .s_ready(s_ready[1]),
    .m_address(m_address[1]), .m_byteenable(m_byteenable[1]),
    .m_chipselect(m_chipselect[1]), .m_write(m_write[1]),
    .m_writedata(m_writedata[1]), .busy(busy[1]), .done(done[1]),
    .word_count(word_count[1]),
`ifdef QBERT_LOADER_CHECKSUM_EN
    .checksum(checksum[1]),
`endif
    .overflow(overflow[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_write[d]) begin
        wcyc.push_back(cyc);
        check("wr_cs", {31'b0, m_chipselect[d]}, 32'd1);
        if (expq.size() == 0) begin
          check("wr_unexpected", {19'b0, m_address[d]}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = expq.pop_front();
          check("wr_addr", {19'b0, m_address[d]}, {19'b0, e.a});
          check("wr_be",   {28'b0, m_byteenable[d]}, {28'b0, e.be});
          check("wr_data", m_writedata[d], e.d);
        end
      end
      if (done[d]) begin
        done_cnt[d]++;
        check("done_sready", {31'b0, s_ready[d]}, 32'd0);
      end
    end
  end

  task automatic send(input int d, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    s_valid[d] = 1'b1;
    s_data[d]  = b;
    s_last[d]  = last;
    while (!s_ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
  endtask

  // Builds expected writes from the byte list, then drives the stream.
  task automatic run_load(input int d, input int n, input logic [7:0] first,
                          input int gapmax, input bit spur);
    int          base, widx, nwr, dc0, k;
    logic [31:0] wd, cs;
    logic [3:0]  be;
    logic        ovf;
    base = (d == 0) ? 0 : 4998;
    widx = 0; nwr = 0; wd = '0; be = '0; cs = '0; ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      wd[(i%4)*8 +: 8] = first + 8'(i);
      be[i%4]          = 1'b1;
      if ((i % 4) == 3 || i == n - 1) begin
        if (base + widx < 5000 && !ovf) begin
          expq.push_back('{a: 13'(base + widx), be: be, d: wd});
          cs = cs + wd;
          nwr++;
        end else begin
          ovf = 1'b1;
        end
        widx++; wd = '0; be = '0;
      end
    end
    dc0 = done_cnt[d];
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      if (spur && i == 2) start[d] = 1'b1;
      send(d, first + 8'(i), i == n - 1);
      start[d] = 1'b0;
    end
    k = 0;
    while (busy[d] && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("busy_timeout", 32'd0, 32'd1);
    check("done_once", done_cnt[d] - dc0, 32'd1);
    check("word_count", {19'b0, word_count[d]}, nwr);
    check("overflow", {31'b0, overflow[d]}, {31'b0, ovf});
    check("queue_empty", expq.size(), 32'd0);
`ifdef QBERT_LOADER_CHECKSUM_EN
    check("checksum", checksum[d], cs);
`endif
    expq.delete();
  endtask

  task automatic check_reset_vals(input int d, input logic [12:0] base);
    check("rst_addr",  {19'b0, m_address[d]}, {19'b0, base});
    check("rst_be",    {28'b0, m_byteenable[d]}, 32'd0);
    check("rst_cs",    {31'b0, m_chipselect[d]}, 32'd0);
    check("rst_wr",    {31'b0, m_write[d]}, 32'd0);
    check("rst_wdata", m_writedata[d], 32'd0);
    check("rst_ready", {31'b0, s_ready[d]}, 32'd0);
    check("rst_busy",  {31'b0, busy[d]}, 32'd0);
    check("rst_done",  {31'b0, done[d]}, 32'd0);
    check("rst_wcnt",  {19'b0, word_count[d]}, 32'd0);
    check("rst_ovf",   {31'b0, overflow[d]}, 32'd0);
`ifdef QBERT_LOADER_CHECKSUM_EN
    check("rst_csum",  checksum[d], 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; s_data[d] = '0; s_valid[d] = 1'b0; s_last[d] = 1'b0;
      done_cnt[d] = 0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals(0, 13'd0);
    check_reset_vals(1, 13'd4998);
    reset = 1'b0;
    @(negedge clk);

    // Two full words back-to-back, no gaps: strobes 5 cycles apart.
    wcyc.delete();
    run_load(0, 8, 8'h01, 0, 1'b0);
    check("wr_count_8", wcyc.size(), 32'd2);
    if (wcyc.size() == 2) check("wr_spacing", wcyc[1] - wcyc[0], 32'd5);

    // Trailing partial word.
    run_load(0, 6, 8'hA0, 0, 1'b0);

    // Random gaps, stray start while busy, odd length.
    run_load(0, 41, 8'h30, 3, 1'b1);

    // Single byte with last.
    run_load(0, 1, 8'hEE, 1, 1'b0);

    // Overflow near the top of memory.
    run_load(1, 12, 8'h10, 1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("ovf_ready_low", {31'b0, s_ready[1]}, 32'd0);
    end

    // Reset in the middle of a word: nothing written, then a clean reload.
    wcyc.delete();
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 3; i++) send(0, 8'h70 + 8'(i), 1'b0);
    reset = 1'b1;
    #1;
    check_reset_vals(0, 13'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_no_write", wcyc.size(), 32'd0);
    run_load(0, 4, 8'h55, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
